// File: rtl/fpu_seq.sv
// rtl/fpu_seq.sv - table-driven FPU operation sequencer
//
// Purpose:
//   Accepts one FPU operation at a time, performs one (f ops) or two
//   (pp ops) lookup-table reads with a TBL_LAT-cycle read latency, then
//   holds the assembled 16-bit result until the consumer takes it.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   req_valid/req_ready        operation handshake (ready only in IDLE)
//   req_op, req_rd, req_rs     opcode {Op0,Op1}, operand a, operand b
//   req_dst                    destination tag carried to res_dst
//   tbl_en, tbl_addr           table read strobe, address {fn, a, b}
//   tbl_rdata                  table data, TBL_LAT cycles after tbl_en
//   res_valid/res_ready        result handshake
//   res_data, res_dst          held result and its tag
//   busy                       high outside IDLE
//   err                        one-cycle pulse for an unsupported opcode
//
// Configuration:
//   FPU_SEQ_NEG_BYPASS_EN      when defined, negf skips the table and
//                              flips the sign bit of rd directly.

module fpu_seq #(
  parameter int TBL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_op,
  input  logic [15:0] req_rd,
  input  logic [15:0] req_rs,
  input  logic [3:0]  req_dst,
  output logic        tbl_en,
  output logic [18:0] tbl_addr,
  input  logic [7:0]  tbl_rdata,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [3:0]  res_dst,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_LO = 3'd1,
    WAIT_LO  = 3'd2,
    ISSUE_HI = 3'd3,
    WAIT_HI  = 3'd4,
    DONE     = 3'd5
  } state_t;

  // Extra wait cycles beyond the first one spent in each WAIT state.
  localparam logic [1:0] CNT_INIT = 2'(TBL_LAT - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  fn_q;
  logic        pp_q;
  logic [15:0] rd_q, rs_q;
  logic [7:0]  lo_q;
  logic [15:0] res_data_q;
  logic [3:0]  res_dst_q;
  logic        err_q;

  logic        dec_ok;
  logic [2:0]  dec_fn;
  logic        dec_pp;
  logic        dec_byp;
  logic        accept;
  logic        take;
  logic        last_lo;
  logic        last_hi;
  logic        unary;
  logic [7:0]  op_a, op_b;

  // Opcode decode
  always_comb begin
    dec_ok = 1'b1;
    dec_fn = 3'd0;
    dec_pp = 1'b0;
    case (req_op)
      8'h60: dec_fn = 3'd0;
      8'h61: begin dec_fn = 3'd0; dec_pp = 1'b1; end
      8'h62: dec_fn = 3'd1;
      8'h63: begin dec_fn = 3'd1; dec_pp = 1'b1; end
      8'h24: dec_fn = 3'd2;
      8'h25: begin dec_fn = 3'd2; dec_pp = 1'b1; end
      8'h28: dec_fn = 3'd3;
      8'h22: dec_fn = 3'd4;
      8'h20: dec_fn = 3'd5;
      default: dec_ok = 1'b0;
    endcase
  end

`ifdef FPU_SEQ_NEG_BYPASS_EN
  assign dec_byp = dec_ok && (dec_fn == 3'd3);
`else
  assign dec_byp = 1'b0;
`endif

  assign accept  = (state_q == IDLE) && req_valid;
  assign take    = accept && dec_ok;
  assign last_lo = (state_q == WAIT_LO) && (cnt_q == 2'd0);
  assign last_hi = (state_q == WAIT_HI) && (cnt_q == 2'd0);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      fn_q       <= 3'd0;
      pp_q       <= 1'b0;
      rd_q       <= 16'h0000;
      rs_q       <= 16'h0000;
      lo_q       <= 8'h00;
      res_data_q <= 16'h0000;
      res_dst_q  <= 4'h0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= accept && !dec_ok;
      if (take) begin
        fn_q      <= dec_fn;
        pp_q      <= dec_pp;
        rd_q      <= req_rd;
        rs_q      <= req_rs;
        res_dst_q <= req_dst;
        if (dec_byp) begin
          res_data_q <= {8'h00, ~req_rd[7], req_rd[6:0]};
        end
      end
      if (last_lo) begin
        lo_q <= tbl_rdata;
        if (!pp_q) begin
          // f2i sign-extends its byte; other f ops zero-extend.
          res_data_q <= (fn_q == 3'd4) ? {{8{tbl_rdata[7]}}, tbl_rdata}
                                       : {8'h00, tbl_rdata};
        end
      end
      if (last_hi) begin
        res_data_q <= {tbl_rdata, lo_q};
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = dec_byp ? DONE : ISSUE_LO;
        end
      end
      ISSUE_LO: begin
        state_d = WAIT_LO;
        cnt_d   = CNT_INIT;
      end
      WAIT_LO: begin
        if (cnt_q == 2'd0) begin
          state_d = pp_q ? ISSUE_HI : DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ISSUE_HI: begin
        state_d = WAIT_HI;
        cnt_d   = CNT_INIT;
      end
      WAIT_HI: begin
        if (cnt_q == 2'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  assign unary = fn_q[2] | fn_q[1];

  always_comb begin
    req_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    tbl_en    = (state_q == ISSUE_LO) || (state_q == ISSUE_HI);
    res_valid = (state_q == DONE);
    op_a      = (state_q == ISSUE_HI) ? rd_q[15:8] : rd_q[7:0];
    op_b      = (state_q == ISSUE_HI) ? rs_q[15:8] : rs_q[7:0];
    if (unary) begin
      op_b = 8'h00;
    end
    tbl_addr  = {fn_q, op_a, op_b};
    res_data  = res_data_q;
    res_dst   = res_dst_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_fpu_seq.sv
// tb/tb_fpu_seq.sv - scoreboard testbench for fpu_seq

module tb_fpu_seq;

  localparam int L = 1;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready;
  logic [7:0]  req_op;
  logic [15:0] req_rd, req_rs;
  logic [3:0]  req_dst;
  logic        tbl_en;
  logic [18:0] tbl_addr;
  logic [7:0]  tbl_rdata;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic [3:0]  res_dst;
  logic        busy, err;

  logic        req_valid3, req_ready3;
  logic [7:0]  req_op3;
  logic [15:0] req_rd3, req_rs3;
  logic [3:0]  req_dst3;
  logic        tbl_en3;
  logic [18:0] tbl_addr3;
  logic [7:0]  tbl_rdata3;
  logic        res_valid3, res_ready3;
  logic [15:0] res_data3;
  logic [3:0]  res_dst3;
  logic        busy3, err3;

  fpu_seq #(.TBL_LAT(L)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rs(req_rs), .req_dst(req_dst),
    .tbl_en(tbl_en), .tbl_addr(tbl_addr), .tbl_rdata(tbl_rdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_dst(res_dst), .busy(busy), .err(err)
  );

  fpu_seq #(.TBL_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op3),
    .req_rd(req_rd3), .req_rs(req_rs3), .req_dst(req_dst3),
    .tbl_en(tbl_en3), .tbl_addr(tbl_addr3), .tbl_rdata(tbl_rdata3),
    .res_valid(res_valid3), .res_ready(res_ready3), .res_data(res_data3),
    .res_dst(res_dst3), .busy(busy3), .err(err3)
  );

  // Table models: a+b mod 256, delivered L (or 3) cycles after the strobe.
  logic [7:0] t1, t3a, t3b, t3c;
  always @(posedge clk) begin
    t1  <= tbl_en ? 8'(tbl_addr[15:8] + tbl_addr[7:0]) : 8'hEE;
    t3a <= tbl_en3 ? 8'(tbl_addr3[15:8] + tbl_addr3[7:0]) : 8'hEE;
    t3b <= t3a;
    t3c <= t3b;
  end
  assign tbl_rdata  = t1;
  assign tbl_rdata3 = t3c;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
  endtask

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dst;
    int          lat;
    int          nreads;
    logic [18:0] addr0;
    logic [18:0] addr1;
    int          acc;
  } exp_t;

  exp_t sb[$];

  // Reference model straight from the opcode table and result rules.
  function automatic bit ref_model(input logic [7:0] op, input logic [15:0] rd,
                                   input logic [15:0] rs, input logic [3:0] dst,
                                   input int acc, input int lat_cfg, output exp_t e);
    logic [2:0] fn;
    bit         pp, ok, unary;
    logic [7:0] alo, blo, ahi, bhi, lo, hi;
    ok = 1'b1; pp = 1'b0; fn = 3'd0;
    case (op)
      8'h60: fn = 3'd0;
      8'h61: begin fn = 3'd0; pp = 1'b1; end
      8'h62: fn = 3'd1;
      8'h63: begin fn = 3'd1; pp = 1'b1; end
      8'h24: fn = 3'd2;
      8'h25: begin fn = 3'd2; pp = 1'b1; end
      8'h28: fn = 3'd3;
      8'h22: fn = 3'd4;
      8'h20: fn = 3'd5;
      default: ok = 1'b0;
    endcase
    unary = (fn >= 3'd2);
    alo = rd[7:0];  blo = unary ? 8'h00 : rs[7:0];
    ahi = rd[15:8]; bhi = unary ? 8'h00 : rs[15:8];
    lo  = alo + blo;
    hi  = ahi + bhi;
    e.addr0 = {fn, alo, blo};
    e.addr1 = {fn, ahi, bhi};
    e.dst   = dst;
    e.acc   = acc;
    if (pp) begin
      e.data = {hi, lo}; e.lat = 2 * (lat_cfg + 1); e.nreads = 2;
    end else begin
      e.data = (fn == 3'd4) ? {{8{lo[7]}}, lo} : {8'h00, lo};
      e.lat = lat_cfg + 1; e.nreads = 1;
    end
`ifdef FPU_SEQ_NEG_BYPASS_EN
    if (ok && fn == 3'd3) begin
      e.data = {8'h00, rd[7:0] ^ 8'h80}; e.lat = 0; e.nreads = 0;
    end
`endif
    return ok;
  endfunction

  // Monitor: compares table reads and results against the scoreboard head.
  logic        prev_valid = 1'b0;
  logic [15:0] held;
  int          nrd = 0;
  always @(negedge clk) begin
    #1;
    if (reset) begin
      prev_valid = 1'b0;
      nrd = 0;
    end else begin
      if (tbl_en) begin
        check("tbl_en_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          if (nrd == 0) begin
            check("read0_cycle", edge_n - sb[0].acc, 0);
            check("read0_addr", tbl_addr, sb[0].addr0);
          end else begin
            check("read1_cycle", edge_n - sb[0].acc, L + 1);
            check("read1_addr", tbl_addr, sb[0].addr1);
          end
        end
        nrd++;
      end
      if (res_valid && !prev_valid) begin
        check("res_valid_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          check("res_latency", edge_n - sb[0].acc, sb[0].lat);
          check("res_data", res_data, sb[0].data);
          check("res_dst", res_dst, sb[0].dst);
        end
        held = res_data;
      end else if (res_valid) begin
        check("res_data_stable", res_data, held);
      end
      if (res_valid && res_ready && sb.size() > 0) begin
        check("read_count", nrd, sb[0].nreads);
        void'(sb.pop_front());
        nrd = 0;
      end
      prev_valid = res_valid;
    end
  end

  // Consumer: random backpressure in mode 0, otherwise driven by the main flow.
  int rr_mode = 1;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rr_mode == 0) res_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [7:0] op, input logic [15:0] rd,
                      input logic [15:0] rs, input logic [3:0] dst);
    exp_t e;
    bit   ok;
    int   n;
    req_valid = 1'b1; req_op = op; req_rd = rd; req_rs = rs; req_dst = dst;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", req_ready, 1);
    ok = ref_model(op, rd, rs, dst, edge_n + 1, L, e);
    if (ok) sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    check("err_pulse", err, !ok);
    if (!ok) check("busy_after_bad", busy, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  logic [7:0] ops [10];
  exp_t       e3;
  bit         ok3;
  int         acc3, nrd3, lat3, n;

  initial begin
    ops = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h24, 8'h25, 8'h28, 8'h22, 8'h20, 8'h70};
    reset = 1'b1; req_valid = 1'b0; req_op = 8'h00; req_rd = 16'h0; req_rs = 16'h0;
    req_dst = 4'h0; res_ready = 1'b0;
    req_valid3 = 1'b0; req_op3 = 8'h00; req_rd3 = 16'h0; req_rs3 = 16'h0;
    req_dst3 = 4'h0; res_ready3 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_tbl_en", tbl_en, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_res_data", res_data, 16'h0000);
    check("rst_res_dst", res_dst, 4'h0);
    reset = 1'b0;

    rr_mode = 2; res_ready = 1'b1;
    send(8'h61, 16'h0102, 16'h0304, 4'h1);
    wait_idle();
    send(8'h28, 16'h0005, 16'($urandom), 4'h2);
    wait_idle();
    send(8'h70, 16'h1234, 16'h5678, 4'h3);
    @(negedge clk);
    check("err_one_cycle", err, 0);
    check("bad_stays_idle", req_ready, 1);

    // Held result with a second request pending.
    rr_mode = 1; res_ready = 1'b0;
    send(8'h60, 16'h0011, 16'h0022, 4'h4);
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("res_valid_seen", res_valid, 1);
    req_valid = 1'b1; req_op = 8'h62; req_rd = 16'h0033; req_rs = 16'h0044; req_dst = 4'h6;
    check("hold_req_ready", req_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_req_ready", req_ready, 0);
      check("hold_res_valid", res_valid, 1);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("ready_after_retire", req_ready, 1);
    check("valid_after_retire", res_valid, 0);
    rr_mode = 2;
    send(8'h62, 16'h0033, 16'h0044, 4'h6);
    wait_idle();

    // Reset during WAIT_HI of a mulpp.
    send(8'h63, 16'hA1B2, 16'h0C0D, 4'h7);
    repeat (3) @(negedge clk);
    check("busy_in_wait_hi", busy, 1);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_res_valid", res_valid, 0);
    check("abort_req_ready", req_ready, 1);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_result", res_valid, 0);
    send(8'h60, 16'h0040, 16'h0002, 4'h8);
    wait_idle();

    // Randomized traffic with random backpressure.
    rr_mode = 0;
    for (int i = 0; i < 40; i++) begin
      send(ops[$urandom_range(0, 9)], 16'($urandom), 16'($urandom), 4'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rr_mode = 2; res_ready = 1'b1;
    wait_idle();

    // f2i through the TBL_LAT=3 instance.
    ok3 = ref_model(8'h22, 16'h00F0, 16'h5A5A, 4'h9, 0, 3, e3);
    check("f2i_model_ok", ok3, 1);
    req_valid3 = 1'b1; req_op3 = 8'h22; req_rd3 = 16'h00F0; req_rs3 = 16'h5A5A;
    req_dst3 = 4'h9;
    acc3 = edge_n + 1;
    @(negedge clk);
    req_valid3 = 1'b0;
    nrd3 = 0; lat3 = -1;
    for (int i = 0; i < 20; i++) begin
      if (tbl_en3) begin
        nrd3++;
        check("lat3_addr", tbl_addr3, e3.addr0);
      end
      if (res_valid3 && lat3 < 0) begin
        lat3 = edge_n - acc3;
        check("lat3_data", res_data3, e3.data);
      end
      @(negedge clk);
    end
    check("lat3_reads", nrd3, e3.nreads);
    check("lat3_latency", lat3, e3.lat);
    res_ready3 = 1'b1;
    @(negedge clk);
    check("lat3_retired", busy3, 0);
    res_ready3 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
